prio_intc: RTL
==============

# prio_intc

Parametrised priority interrupt controller: the next generation of the team's generic interrupt controller. It adds per-source edge/level triggering, a priority threshold, and a claim/complete handshake with per-source in-service tracking. It also has a pulse-mode output FSM that re-fires after each completion. It sits between peripheral interrupt lines and a single CPU interrupt pin, and its configuration comes from the register file.

## Interface
- N, 16: number of interrupt sources (N ≥ 2)
- P, 3: priority width; priority 0 means never interrupt
- W, 8: pulse-width counter width
- IW, $clog2(N): source-ID width (derived, not overridden)
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- int_in  in  N  raw interrupt lines, already synchronous to clk
- int_enable  in  N  per-source enable
- int_trig  in  N  per-source trigger: 0 = level, 1 = rising edge
- int_priority  in  N×P  per-source priority
- int_clear  in  N  per-source pending clear, one-cycle strobe
- threshold  in  P  only sources with priority > threshold are eligible
- out_mode  in  1  0 = level, 1 = pulse
- out_polarity  in  1  0 = active-low, 1 = active-high
- pulse_width  in  W  pulse length in cycles; 0 is treated as 1
- claim_req  in  1  claim strobe
- claim_ack  out  1  one-cycle response to claim_req
- claim_id  out  IW  claimed source ID, valid with claim_ack
- claim_valid  out  1  with claim_ack: 1 = real claim, 0 = nothing eligible
- complete_req  in  1  completion strobe
- complete_id  in  IW  source being completed
- int_status  out  N  pending register
- int_busy  out  N  in-service register
- int_vector  out  IW  best eligible source (0 when none)
- int_vld  out  1  some source eligible
- int_out  out  1  interrupt pin after polarity

## Operation
- **Trigger detection**
  - Level source: triggers while int_in & int_enable.
  - Edge source: triggers on a rising edge of int_in while enabled. The previous-value register updates every cycle regardless of enable.
- **Pending**
  - Set by a trigger; cleared by int_clear or by a claim of that source.
  - If set and clear land in the same cycle, the set wins.
  - Level sources: pending also drops when int_in is low and the source is not busy.
  - Edge sources: an edge arriving while busy still sets pending.
- **Busy (in service)**
  - Set by a claim.
  - Cleared by complete_req with a matching complete_id.
  - A complete for a source that is not busy is ignored.
- **Eligibility:** pending & ~busy & enable & (priority > threshold).
- **Arbitration:** combinational over eligible sources. Highest priority wins; ties go to the lowest index. The result drives int_vector and int_vld.
- **Claim**
  - claim_req samples the arbiter.
  - The following cycle, claim_ack = 1 with claim_id/claim_valid registered.
  - The claimed source's pending clears and its busy sets, both on the sampling edge.
- **Output FSM** (pulse mode), states IDLE, PULSE, ARMED:
  - IDLE → PULSE when int_vld is 1; the counter loads max(pulse_width,1) − 1.
  - PULSE: raw output = 1; the counter decrements; at 0 go to ARMED.
  - ARMED: raw output = 0. Return to IDLE on a claim, on a completion, or when int_vld drops.
  - Level mode: raw output = int_vld, and the FSM is held in IDLE.
  - A change to out_mode forces the FSM to IDLE.
- int_out = out_polarity ? raw : ~raw.

## Timing
- **Reset values:**
  - pending, busy, edge history: 0
  - FSM: IDLE
  - claim_ack, claim_valid, claim_id: 0
  - int_out = ~out_polarity (combinational from the inputs)
- **Latencies:**
  - Trigger to int_status: 1 cycle.
  - Trigger to int_vld (level mode, int_out): 1 cycle.
  - Trigger to the first pulse cycle: 2 cycles.
- A pulse lasts exactly max(pulse_width,1) cycles. Each subsequent re-arm costs at least 1 IDLE cycle.
- **Same-cycle events:**
  - Claim and complete of the same source: the complete acts on the old busy state, then the claim sets busy. Net result is busy = 1.
  - Claim while int_clear targets the winning source: the claim still succeeds.
- Back-to-back claim_req: each gets its own ack. The second sees the updated busy/pending state.
- Changing threshold or priority takes effect the next cycle; sources already busy are unaffected.

## Structure
- Package prio_intc_pkg:
  - trig_e (LEVEL, EDGE)
  - out_state_e (IDLE, PULSE, ARMED)
  - localparams for the mode encodings
- Sub-module intc_gateway: instantiated N times; holds edge history, pending and busy for one source.
- The top level holds the arbiter, claim pipeline and output FSM.

## Test plan
- **Level source:** source 3 level, priority 2, threshold 0; int_in[3]=1.
  - Cycle +1: int_status[3]=1 and int_vector=3.
  - Claim: claim_id=3 and claim_valid=1; int_vld=0 while busy.
  - Complete with int_in still high: pending again.
- **Arbitration:** sources 1 and 5 both priority 4, source 2 priority 3, all pending → int_vector=1. Claim source 1 → int_vector=5.
- **Threshold:** threshold=4 with a source at priority 4 → int_vld=0. Set threshold=3 → int_vld=1 next cycle.
- **Edge:** source 0 edge-triggered, rising edge, claim, second edge before complete → pending=1, busy=1. After complete, int_vld=1.
- **Pulse mode:** out_mode=1, pulse_width=3, polarity=0 → int_out low for exactly 3 cycles and stays high until claim; the next pulse follows the completion. Repeat with pulse_width=0 → 1-cycle pulse.
- **Reset mid-pulse:** rst_n low during PULSE → all state clears and int_out=~out_polarity.

Source files
------------

// File: rtl/prio_intc_pkg.sv
// Shared types and mode encodings for the priority interrupt controller.
package prio_intc_pkg;

   typedef enum logic {
      LEVEL = 1'b0,
      EDGE  = 1'b1
   } trig_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      ARMED = 2'd2
   } out_state_e;

   localparam logic MODE_LEVEL = 1'b0;
   localparam logic MODE_PULSE = 1'b1;
   localparam logic POL_HIGH   = 1'b1;

endpackage

// File: rtl/intc_gateway.sv
// Per-source gateway: trigger detection, pending and in-service tracking.
module intc_gateway
   import prio_intc_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  line,
   input  logic  enable,
   input  trig_e trig,
   input  logic  clear,
   input  logic  claim,
   input  logic  complete,
   output logic  pending,
   output logic  busy
);

   logic prev;
   logic set_c;
   logic drop_c;

   // A level source re-requests only once it is out of service and not being claimed.
   always_comb begin
      set_c  = 1'b0;
      drop_c = 1'b0;
      if (trig == EDGE) begin
         set_c = line & ~prev & enable;
      end else begin
         set_c  = line & enable & ~busy & ~claim;
         drop_c = ~line & ~busy;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev    <= 1'b0;
         pending <= 1'b0;
         busy    <= 1'b0;
      end else begin
         prev    <= line;
         pending <= set_c | (pending & ~clear & ~claim & ~drop_c);
         busy    <= claim | (busy & ~complete);
      end
   end

endmodule

// File: rtl/prio_intc.sv
// Priority interrupt controller: arbiter, claim/complete pipeline and output FSM.
module prio_intc
   import prio_intc_pkg::*;
#(
   parameter  int unsigned N  = 16,
   parameter  int unsigned P  = 3,
   parameter  int unsigned W  = 8,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    int_in,
   input  logic [N-1:0]    int_enable,
   input  logic [N-1:0]    int_trig,
   input  logic [N*P-1:0]  int_priority,
   input  logic [N-1:0]    int_clear,
   input  logic [P-1:0]    threshold,
   input  logic            out_mode,
   input  logic            out_polarity,
   input  logic [W-1:0]    pulse_width,
   input  logic            claim_req,
   output logic            claim_ack,
   output logic [IW-1:0]   claim_id,
   output logic            claim_valid,
   input  logic            complete_req,
   input  logic [IW-1:0]   complete_id,
   output logic [N-1:0]    int_status,
   output logic [N-1:0]    int_busy,
   output logic [IW-1:0]   int_vector,
   output logic            int_vld,
   output logic            int_out
);

   logic [N-1:0]  pending;
   logic [N-1:0]  busy;
   logic [N-1:0]  eligible;
   logic [N-1:0]  claim_vec;
   logic [N-1:0]  complete_vec;
   logic [P-1:0]  prio [N];
   logic [P-1:0]  best_prio;
   logic [IW-1:0] best_id;
   logic          found;
   out_state_e    state;
   logic [W-1:0]  cnt;
   logic [W-1:0]  load_c;
   logic          mode_q;
   logic          raw_c;

   for (genvar g = 0; g < N; g++) begin : g_src
      intc_gateway u_gw (
         .clk      (clk),
         .rst_n    (rst_n),
         .line     (int_in[g]),
         .enable   (int_enable[g]),
         .trig     (trig_e'(int_trig[g])),
         .clear    (int_clear[g]),
         .claim    (claim_vec[g]),
         .complete (complete_vec[g]),
         .pending  (pending[g]),
         .busy     (busy[g])
      );
   end

   // Eligibility plus arbitration: highest priority wins, ties go to lowest index.
   always_comb begin
      best_id   = '0;
      best_prio = '0;
      found     = 1'b0;
      for (int i = 0; i < N; i++) begin
         prio[i]     = int_priority[i*P +: P];
         eligible[i] = pending[i] & ~busy[i] & int_enable[i] & (prio[i] > threshold);
         if (eligible[i] && (!found || (prio[i] > best_prio))) begin
            found     = 1'b1;
            best_id   = IW'(i);
            best_prio = prio[i];
         end
      end
   end

   assign int_status = pending;
   assign int_busy   = busy;
   assign int_vector = best_id;
   assign int_vld    = found;

   always_comb begin
      claim_vec    = '0;
      complete_vec = '0;
      for (int i = 0; i < N; i++) begin
         claim_vec[i]    = claim_req & found & (best_id == IW'(i));
         complete_vec[i] = complete_req & (complete_id == IW'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         claim_ack   <= 1'b0;
         claim_id    <= '0;
         claim_valid <= 1'b0;
      end else begin
         claim_ack   <= claim_req;
         claim_valid <= claim_req & found;
         if (claim_req) begin
            claim_id <= best_id;
         end
      end
   end

   assign load_c = (pulse_width == '0) ? '0 : pulse_width - W'(1);

   // Pulse-mode output sequencer; parked in IDLE in level mode or on a mode change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         mode_q <= MODE_LEVEL;
      end else begin
         mode_q <= out_mode;
         if ((out_mode != mode_q) || (out_mode == MODE_LEVEL)) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (found) begin
                     state <= PULSE;
                     cnt   <= load_c;
                  end
               end
               PULSE: begin
                  if (cnt == '0) begin
                     state <= ARMED;
                  end else begin
                     cnt <= cnt - W'(1);
                  end
               end
               ARMED: begin
                  if (claim_req || complete_req || !found) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign raw_c   = (out_mode == MODE_PULSE) ? (state == PULSE) : found;
   assign int_out = (out_polarity == POL_HIGH) ? raw_c : ~raw_c;

endmodule
